// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared sizes, state encoding and helpers for the mux round-robin arbiter
package mux_arb_pkg;

    localparam int N_SRC = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // One-hot grant vector for a source index
    function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_SRC-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// rtl/mux_rr_pick.sv - rotating priority encoder: first set req bit at or above ptr, wrapping
module mux_rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester to ptr wins last
    always_comb begin
        any  = 1'b0;
        idx  = ptr;
        cand = ptr;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - burst-limited round-robin arbiter driving a registered 8:1 data mux (optional MUX_ARB_LOCK_EN adds lock)
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
)(
    input  logic             clk,
    input  logic             rst,
`ifdef MUX_ARB_LOCK_EN
    input  logic             lock,
`endif
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] in,
    output logic [N_SRC-1:0] gnt,
    output logic [SEL_W-1:0] s,
    output logic             out,
    output logic             out_vld
);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] count;

    logic [SEL_W-1:0] pick_ptr;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             others;
    logic             hold;
    logic             grant_end;

`ifdef MUX_ARB_LOCK_EN
    // Lock only matters while the current owner is still requesting
    assign hold = lock & req[s];
`else
    assign hold = 1'b0;
`endif

    // While granting, the next winner is searched from s+1 so a hand-off needs no idle cycle
    assign pick_ptr  = (state == GRANT) ? s + SEL_W'(1) : ptr;
    assign others    = |(req & ~gnt);
    assign grant_end = ~req[s] | ((count == BURST_MAX) & others & ~hold);

    mux_rr_pick u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Arbitration FSM with registered grant, select, burst count and mux output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            s       <= '0;
            out     <= 1'b0;
            out_vld <= 1'b0;
            ptr     <= '0;
            count   <= '0;
        end else begin
            out     <= in[s];
            out_vld <= (state == GRANT);
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state <= GRANT;
                        gnt   <= onehot(pick_idx);
                        s     <= pick_idx;
                        count <= CNT_W'(1);
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        ptr <= s + SEL_W'(1);
                        if (pick_any) begin
                            gnt   <= onehot(pick_idx);
                            s     <= pick_idx;
                            count <= CNT_W'(1);
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end else if (count != BURST_MAX) begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule
